// File: rtl/timer_ctrl_nbit_pkg.sv
// timer_ctrl_nbit_pkg: shared state encoding for the timer sequencing controller.
package timer_ctrl_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/timer_ctrl_nbit_tick_counter.sv
// tick_counter: L-bit up-counter with synchronous clear and enable, async active-low reset.
module tick_counter #(
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [L-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + L'(1);
    end
endmodule

// File: rtl/timer_ctrl_nbit.sv
// timer_ctrl_nbit: start/hold/abort sequencer for an L-bit up-counter with period match and done pulse.
// Optional build macro PRESCALE_EN adds an internal prescaler so the count steps every PRESCALE RUN cycles.
module timer_ctrl_nbit
    import timer_ctrl_pkg::*;
#(
    parameter int L        = 4,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic               auto_reload,
    input  logic [L-1:0]       period,
    output logic [L-1:0]       count,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be >= 1");
    end
    state_t       state_q, state_d;
    logic [L-1:0] period_q;
    logic         mode_q;
    logic         done_q;
    logic         accept, run_go, step, match, clr, en, done_d;
    assign accept = state_q == IDLE && start && !abort;
    assign run_go = state_q == RUN && !hold && !abort;
    assign match  = count == period_q;
`ifdef PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre_q;
    logic          pre_last;
    assign pre_last = pre_q == PW'(PRESCALE - 1);
    assign step     = run_go && pre_last;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_q <= '0;
        else if (abort || accept)
            pre_q <= '0;
        else if (run_go)
            pre_q <= pre_last ? '0 : pre_q + PW'(1);
    end
`else
    assign step = run_go;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                period_q <= period;
                mode_q   <= auto_reload;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = hold ? HOLD : (step && match && !mode_q) ? IDLE : RUN;
            HOLD:    state_d = hold ? HOLD : RUN;
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end
    // A one-shot match leaves count parked at period_q; auto-reload clears it.
    always_comb begin
        clr    = abort || accept || (step && match && mode_q);
        en     = step && !match;
        done_d = step && match;
    end
    tick_counter #(.L(L)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .q   (count)
    );
    assign busy  = state_q != IDLE;
    assign done  = done_q;
    assign state = state_q;
endmodule

// File: tb/tb_timer_ctrl_nbit.sv
// tb_timer_ctrl_nbit: directed scoreboard bench for timer_ctrl_nbit (L=4, PRESCALE=4).
module tb_timer_ctrl_nbit;
    localparam int L = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, abort = 1'b0, hold = 1'b0, auto_reload = 1'b0;
    logic [L-1:0] period = '0;
    logic [L-1:0] count;
    logic         busy, done;
    logic [1:0]   state;
    typedef struct {
        string        tag;
        logic [L-1:0] c;
        logic         b;
        logic         d;
        logic [1:0]   s;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    timer_ctrl_nbit #(.L(L), .PRESCALE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .auto_reload (auto_reload),
        .period      (period),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );
    always #5 clk = ~clk;
    task automatic push(input string tag, input int c, input bit b, input bit d, input int s);
        exp_t e;
        e.tag = tag;
        e.c   = L'(c);
        e.b   = b;
        e.d   = d;
        e.s   = 2'(s);
        sb.push_back(e);
    endtask
    // Drive one cycle of inputs and queue the outputs expected after the following edge.
    task automatic step(input string tag, input bit s_, input bit a_, input bit h_, input bit r_,
                        input int p_, input int c, input bit b, input bit d, input int s);
        @(negedge clk);
        start       = s_;
        abort       = a_;
        hold        = h_;
        auto_reload = r_;
        period      = L'(p_);
        @(posedge clk);
        push(tag, c, b, d, s);
    endtask
    task automatic do_reset(input string tag);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        #1 rst = 1'b0;
        #1 push(tag, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (count === e.c && busy === e.b && done === e.d && state === e.s)
                passes++;
            else
                $display("FAIL %s: got count=%0d busy=%0b done=%0b state=%0d, want count=%0d busy=%0b done=%0b state=%0d",
                         e.tag, count, busy, done, state, e.c, e.b, e.d, e.s);
        end
    end
    initial begin
        #1 push("reset", 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
`ifdef PRESCALE_EN
        step("ps_start", 1, 0, 0, 0, 2, 0, 1, 0, 1);
        for (int e = 1; e <= 11; e++) step("ps_cnt", 0, 0, 0, 0, 0, e / 4, 1, 0, 1);
        step("ps_done", 0, 0, 0, 0, 0, 2, 0, 1, 0);
        step("ps_idle", 0, 0, 0, 0, 0, 2, 0, 0, 0);
        step("ps_rs", 1, 0, 0, 0, 2, 0, 1, 0, 1);
        for (int e = 1; e <= 5; e++) step("ps_rs_cnt", 0, 0, 0, 0, 0, e / 4, 1, 0, 1);
        do_reset("ps_midrun_reset");
`else
        step("os_start", 1, 0, 0, 0, 5, 0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) step("os_cnt", 0, 0, 0, 0, 0, i, 1, 0, 1);
        step("os_done", 0, 0, 0, 0, 0, 5, 0, 1, 0);
        step("os_idle", 0, 0, 0, 0, 0, 5, 0, 0, 0);
        step("ar_start", 1, 0, 0, 1, 3, 0, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i <= 3; i++) step("ar_cnt", 0, 0, 0, 0, 0, i, 1, 0, 1);
            step("ar_done", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        end
        step("ar_start_ignored", 1, 0, 0, 0, 9, 1, 1, 0, 1);
        step("ar_cnt2", 0, 0, 0, 0, 0, 2, 1, 0, 1);
        step("ar_cnt3", 0, 0, 0, 0, 0, 3, 1, 0, 1);
        step("ar_period_kept", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("ar_abort", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("p0_start", 1, 0, 0, 1, 0, 0, 1, 0, 1);
        repeat (3) step("p0_done", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("p0_abort", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("p0os_start", 1, 0, 0, 0, 0, 0, 1, 0, 1);
        step("p0os_done", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("hd_start", 1, 0, 0, 0, 5, 0, 1, 0, 1);
        step("hd_c1", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("hd_c2", 0, 0, 0, 0, 0, 2, 1, 0, 1);
        step("hd_enter", 0, 0, 1, 0, 0, 2, 1, 0, 2);
        step("hd_stay", 0, 0, 1, 0, 0, 2, 1, 0, 2);
        step("hd_exit", 0, 0, 0, 0, 0, 2, 1, 0, 1);
        for (int i = 3; i <= 5; i++) step("hd_cnt", 0, 0, 0, 0, 0, i, 1, 0, 1);
        step("hd_done", 0, 0, 0, 0, 0, 5, 0, 1, 0);
        step("hm_start", 1, 0, 0, 0, 1, 0, 1, 0, 1);
        step("hm_c1", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("hm_hold_at_match", 0, 0, 1, 0, 0, 1, 1, 0, 2);
        step("hm_exit", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("hm_done", 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("ab_start", 1, 0, 0, 0, 9, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) step("ab_cnt", 0, 0, 0, 0, 0, i, 1, 0, 1);
        step("ab_run", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("ab_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("ab_with_start", 1, 1, 0, 0, 9, 0, 0, 0, 0);
        step("ah_start", 1, 0, 0, 0, 9, 0, 1, 0, 1);
        step("ah_c1", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("ah_hold", 0, 0, 1, 0, 0, 1, 1, 0, 2);
        step("ah_abort", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("max_start", 1, 0, 0, 0, 15, 0, 1, 0, 1);
        for (int i = 1; i <= 15; i++) step("max_cnt", 0, 0, 0, 0, 0, i, 1, 0, 1);
        step("max_done", 0, 0, 0, 0, 0, 15, 0, 1, 0);
        step("mr_start", 1, 0, 0, 0, 7, 0, 1, 0, 1);
        step("mr_c1", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("mr_c2", 0, 0, 0, 0, 0, 2, 1, 0, 1);
        do_reset("midrun_reset");
        step("pr_start", 1, 0, 0, 0, 2, 0, 1, 0, 1);
        step("pr_c1", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("pr_c2", 0, 0, 0, 0, 0, 2, 1, 0, 1);
        step("pr_done", 0, 0, 0, 0, 0, 2, 0, 1, 0);
`endif
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0)
            passes++;
        else
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
